// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared constants and helpers for the seven-segment scanner
//
// Purpose: segment-off constant and an index-width helper used to size the
// digit index and slot counter.
// Ports: none (package).
// Optional build macro used elsewhere in this slice: SEV_SEG_LEADING_ZERO_BLANK_EN.

package sev_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/sev_seg_digit_mapper.sv
// rtl/sev_seg_digit_mapper.sv - combinational hex nibble to seven-segment decoder
//
// Purpose: maps a 4-bit hex value to active-high segments {g,f,e,d,c,b,a}.
// Ports:
//   nibble  in   4  hex digit 0..F
//   seg     out  7  segment pattern {g,f,e,d,c,b,a}

module sev_seg_digit_mapper
  import sev_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - time-multiplexed seven-segment display scanner
//
// Purpose: latches a packed hex value and decimal points (double buffered so a
// frame never shows mixed data), scans one digit per PRESCALE-cycle slot with
// BLANK_CYCLES of all-off time at each slot start, and drives registered
// segment, decimal point and one-hot digit select outputs.
// Build macro: SEV_SEG_LEADING_ZERO_BLANK_EN - blank segments of non-zero digit
// positions whose nibble and all higher nibbles are zero.
// Ports:
//   clk         in   1         system clock
//   rst_n       in   1         asynchronous active-low reset
//   enable      in   1         display on; low forces outputs off, scan continues
//   load        in   1         single-cycle strobe capturing value/dots
//   value       in   4*DIGITS  nibble i drives digit i (digit 0 rightmost)
//   dots        in   DIGITS    decimal point per digit
//   segments    out  7         {g,f,e,d,c,b,a}, active-high
//   dp          out  1         decimal point, active-high
//   digit_sel   out  DIGITS    one-hot digit enable, active-high
//   frame_done  out  1         one-cycle pulse at the end of every full scan

module sev_seg_scanner
  import sev_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int CW = idx_width(PRESCALE);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    shadow_value;
  logic [DIGITS-1:0]      shadow_dots;
  logic [4*DIGITS-1:0]    disp_value;
  logic [DIGITS-1:0]      disp_dots;
  logic                   pending;

  logic                   cnt_last;
  logic                   idx_last;
  logic                   frame_end;
  logic                   vis;
  logic [3:0]             sel_nibble;
  logic                   sel_dot;
  logic [DIGITS-1:0]      onehot;
  logic [6:0]             decoded;
  logic [6:0]             seg_next;

  assign cnt_last  = (cnt == CW'(PRESCALE - 1));
  assign idx_last  = (idx == IW'(DIGITS - 1));
  assign frame_end = cnt_last && idx_last;
  assign vis       = enable && (cnt >= CW'(BLANK_CYCLES));

  // Select the displayed digit's nibble, dot and one-hot code without a
  // variable part-select, so non-power-of-two DIGITS stays clean.
  always_comb begin
    sel_nibble = 4'h0;
    sel_dot    = 1'b0;
    onehot     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_nibble = disp_value[4*i +: 4];
        sel_dot    = disp_dots[i];
        onehot[i]  = 1'b1;
      end
    end
  end

  sev_seg_digit_mapper u_mapper (
    .nibble (sel_nibble),
    .seg    (decoded)
  );

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // True when this digit and every more-significant digit hold zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= idx) && (disp_value[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end

  // Digit 0 is never blanked so a zero value still reads "0".
  assign seg_next = ((idx != '0) && upper_zero) ? SEG_OFF : decoded;
`else
  assign seg_next = decoded;
`endif

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer: a load landing on the frame boundary bypasses the shadow so
  // the newest data is shown without waiting a whole extra frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dots  <= '0;
      disp_value   <= '0;
      disp_dots    <= '0;
      pending      <= 1'b0;
    end else if (load && frame_end) begin
      disp_value <= value;
      disp_dots  <= dots;
      pending    <= 1'b0;
    end else if (load) begin
      shadow_value <= value;
      shadow_dots  <= dots;
      pending      <= 1'b1;
    end else if (frame_end && pending) begin
      disp_value <= shadow_value;
      disp_dots  <= shadow_dots;
      pending    <= 1'b0;
    end
  end

  // Registered pin drivers, one cycle behind cnt/idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments   <= SEG_OFF;
      dp         <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      segments   <= vis ? seg_next : SEG_OFF;
      dp         <= vis ? sel_dot : 1'b0;
      digit_sel  <= vis ? onehot : '0;
      frame_done <= frame_end;
    end
  end

endmodule
